battle_sequencer: RTL

//  Parametrised turn/phase sequencer for the battle screen; sits under top level in place of a fixed 3-state game FSM.

---
 rtl/battle_sequencer_if.sv | 34 +++
 rtl/battle_sequencer.sv | 96 +++++++++
 2 files changed

// File: rtl/battle_sequencer_if.sv
// battle_sequencer_if: phase flags, HP strobes, pixels in; phase, reset pulses, HP, status, pixel out
interface battle_sequencer_if #(
  parameter int NUM_PHASES = 3,
  parameter int PHASE_W    = 2,
  parameter int HP_W       = 8,
  parameter int ROUND_W    = 8
);
  logic [NUM_PHASES-1:0]    finished_in;
  logic                     damage_in;
  logic [HP_W-1:0]          damage_amt_in;
  logic                     hit_in;
  logic [HP_W-1:0]          hit_amt_in;
  logic [NUM_PHASES*12-1:0] pixel_in;
  logic [11:0]              overlay_in;
  logic [PHASE_W-1:0]       phase_out;
  logic [NUM_PHASES-1:0]    phase_rst_out;
  logic                     round_rst_out;
  logic [ROUND_W-1:0]       round_count_out;
  logic [HP_W-1:0]          player_hp_out;
  logic [HP_W-1:0]          enemy_hp_out;
  logic                     game_over_out;
  logic                     win_out;
  logic [11:0]              pixel_out;
  modport master (
    output finished_in, damage_in, damage_amt_in, hit_in, hit_amt_in, pixel_in, overlay_in,
    input  phase_out, phase_rst_out, round_rst_out, round_count_out, player_hp_out, enemy_hp_out,
           game_over_out, win_out, pixel_out
  );
  modport slave (
    input  finished_in, damage_in, damage_amt_in, hit_in, hit_amt_in, pixel_in, overlay_in,
    output phase_out, phase_rst_out, round_rst_out, round_count_out, player_hp_out, enemy_hp_out,
           game_over_out, win_out, pixel_out
  );
endinterface

// File: rtl/battle_sequencer.sv
// battle_sequencer: cycles phases on finish edges, pulses resets, tracks HP, composites the phase pixel with the overlay
module battle_sequencer #(
  parameter int NUM_PHASES = 3,
  parameter int PHASE_W    = 2,
  parameter int HP_W       = 8,
  parameter int PLAYER_HP  = 20,
  parameter int ENEMY_HP   = 40,
  parameter int ROUND_W    = 8
) (
  input logic               clk,
  input logic               rst,
  battle_sequencer_if.slave bus
);
  typedef enum logic [1:0] {RUN, ROUND_RST, GAME_OVER, WIN} state_t;
  state_t                state_q, state_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [NUM_PHASES-1:0] phase_rst_q, phase_rst_d;
  logic                  round_rst_q, round_rst_d;
  logic [ROUND_W-1:0]    round_q, round_d;
  logic [HP_W-1:0]       php_q, php_d;
  logic [HP_W-1:0]       ehp_q, ehp_d;
  logic [NUM_PHASES-1:0] fin_q, fin_d;
  logic [11:0]           pix_q, pix_d;
  logic [NUM_PHASES-1:0] edges;
  logic [11:0]           sel;
  logic                  live, adv, last;
  function automatic logic [3:0] sat4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction
  always_comb begin
    live = state_q == RUN || state_q == ROUND_RST;
    edges = bus.finished_in & ~fin_q;
    fin_d = state_q == ROUND_RST ? '0 : bus.finished_in;
    adv = state_q == RUN && edges[phase_q];
    last = phase_q == PHASE_W'(NUM_PHASES - 1);
    php_d = live && bus.damage_in ? (php_q > bus.damage_amt_in ? php_q - bus.damage_amt_in : '0) : php_q;
    ehp_d = live && bus.hit_in ? (ehp_q > bus.hit_amt_in ? ehp_q - bus.hit_amt_in : '0) : ehp_q;
    state_d = state_q;
    phase_d = phase_q;
    phase_rst_d = '0;
    round_rst_d = 1'b0;
    round_d = round_q;
    if (live) begin
      if (php_d == '0) state_d = GAME_OVER;
      else if (ehp_d == '0) state_d = WIN;
      else if (adv && last) begin
        state_d = ROUND_RST;
        phase_d = '0;
        phase_rst_d = '1;
        round_rst_d = 1'b1;
        round_d = round_q + 1'b1;
      end else if (adv) begin
        state_d = RUN;
        phase_d = phase_q + 1'b1;
        phase_rst_d[phase_q] = 1'b1;
      end else state_d = RUN;
    end
    sel = bus.pixel_in[int'(phase_q) * 12 +: 12];
    pix_d = live ? {sat4(sel[11:8], bus.overlay_in[11:8]), sat4(sel[7:4], bus.overlay_in[7:4]),
                    sat4(sel[3:0], bus.overlay_in[3:0])} : bus.overlay_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      phase_q <= '0;
      phase_rst_q <= '0;
      round_rst_q <= 1'b0;
      round_q <= '0;
      php_q <= HP_W'(PLAYER_HP);
      ehp_q <= HP_W'(ENEMY_HP);
      fin_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      phase_rst_q <= phase_rst_d;
      round_rst_q <= round_rst_d;
      round_q <= round_d;
      php_q <= php_d;
      ehp_q <= ehp_d;
      fin_q <= fin_d;
      pix_q <= pix_d;
    end
  end
  assign bus.phase_out = phase_q;
  assign bus.phase_rst_out = phase_rst_q;
  assign bus.round_rst_out = round_rst_q;
  assign bus.round_count_out = round_q;
  assign bus.player_hp_out = php_q;
  assign bus.enemy_hp_out = ehp_q;
  assign bus.game_over_out = state_q == GAME_OVER;
  assign bus.win_out = state_q == WIN;
  assign bus.pixel_out = pix_q;
endmodule
